// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   clk    - sole clock; all state updates on the rising edge
//   reset  - synchronous, active-high reset
//   start  - launch the op on md_op (accepted only when idle and not flushed)
//   flush  - pipeline flush; suppresses a same-cycle start, never aborts a RUN
//   md_op  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO,
//            6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU (6-9 need MULDIV_MADD_EN), 10-15 reserved
//   src_a  - rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b  - rt operand (divisor / multiplier)
//   busy   - an operation is in flight
//   done   - one-cycle pulse in the cycle after HI/LO commit
//   hi, lo - architectural HI and LO registers
//
// Optional feature: define MULDIV_MADD_EN to enable the multiply-accumulate ops 6-9.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [3:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  logic legal_op;
  logic accept;

  always_comb begin
    legal_op = (md_op <= OP_MTLO);
`ifdef MULDIV_MADD_EN
    legal_op = (md_op <= OP_MSUBU);
`endif
  end

  // busy mirrors state==RUN, so it doubles as the "not idle" term here
  assign accept = start & ~flush & ~busy & legal_op;

  // Arithmetic works only on captured operands, so src_a/src_b may change freely during RUN
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
  logic               div_zero, div_ovf;

  assign prod_s   = $signed({{WIDTH{cap_a[WIDTH-1]}}, cap_a}) *
                    $signed({{WIDTH{cap_b[WIDTH-1]}}, cap_b});
  assign prod_u   = {{WIDTH{1'b0}}, cap_a} * {{WIDTH{1'b0}}, cap_b};
  assign div_zero = (cap_b == '0);
  assign div_ovf  = (cap_a == MOST_NEG) && (cap_b == '1);
  assign quot_s   = $signed(cap_a) / $signed(cap_b);
  assign rem_s    = $signed(cap_a) % $signed(cap_b);
  assign quot_u   = cap_a / cap_b;
  assign rem_u    = cap_a % cap_b;

  logic               commit_en;
  logic [2*WIDTH-1:0] commit_val;

  // Result selected at the final busy cycle; divide-by-zero leaves HI/LO untouched
  always_comb begin
    commit_en  = 1'b1;
    commit_val = {hi, lo};
    case (cap_op)
      OP_MULT:  commit_val = prod_s;
      OP_MULTU: commit_val = prod_u;
      OP_DIV: begin
        if (div_zero)     commit_en  = 1'b0;
        else if (div_ovf) commit_val = {{WIDTH{1'b0}}, MOST_NEG};
        else              commit_val = {rem_s, quot_s};
      end
      OP_DIVU: begin
        if (div_zero) commit_en  = 1'b0;
        else          commit_val = {rem_u, quot_u};
      end
`ifdef MULDIV_MADD_EN
      OP_MADD:  commit_val = {hi, lo} + prod_s;
      OP_MADDU: commit_val = {hi, lo} + prod_u;
      OP_MSUB:  commit_val = {hi, lo} - prod_s;
      OP_MSUBU: commit_val = {hi, lo} - prod_u;
`endif
      default:  commit_en  = 1'b0;
    endcase
  end

  // Single FSM: MTHI/MTLO complete at the accepting edge, everything else enters RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cap_op <= '0;
      cap_a  <= '0;
      cap_b  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (md_op == OP_MTHI) begin
              hi <= src_a;
            end else if (md_op == OP_MTLO) begin
              lo <= src_a;
            end else begin
              cap_op <= md_op;
              cap_a  <= src_a;
              cap_b  <= src_b;
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= (md_op == OP_DIV || md_op == OP_DIVU) ? CW'(DIV_CYCLES)
                                                              : CW'(MULT_CYCLES);
            end
          end
        end
        RUN: begin
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            if (commit_en) {hi, lo} <= commit_val;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32, MULT 5, DIV 10).
// Ports of the DUT are driven one time unit after each rising edge and sampled there too.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int n;

  muldiv_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
  endtask

  // Launch an op, clock the accepting edge, then scramble operands to prove capture
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(op, a, b);
    step();
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Counts busy cycles from the current cycle; stops in the first non-busy cycle
  task automatic runToDone(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; md_op = 4'd0; src_a = '0; src_b = '0;
    step(); step();
    reset = 1'b0;
    checkOutput("reset_hi",   hi,   32'h0);
    checkOutput("reset_lo",   lo,   32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);

    // MULT -2 * 3: busy for 5 cycles with HI/LO held, then commit and done
    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("mult_busy", {31'b0, busy}, 32'h1);
      checkOutput("mult_hold_lo", lo, 32'h0);
      step();
    end
    checkOutput("mult_busy_end", {31'b0, busy}, 32'h0);
    checkOutput("mult_done", {31'b0, done}, 32'h1);
    checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
    checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
    step();
    checkOutput("mult_done_pulse", {31'b0, done}, 32'h0);

    // DIV -7 / 2
    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    runToDone(n);
    checkOutput("div_cycles", n, 32'd10);
    checkOutput("div_done", {31'b0, done}, 32'h1);
    checkOutput("div_lo", lo, 32'hFFFF_FFFD);
    checkOutput("div_hi", hi, 32'hFFFF_FFFF);
    step();

    // DIVU 7 / 0 leaves HI/LO alone
    issue(4'd3, 32'd7, 32'd0);
    runToDone(n);
    checkOutput("divz_cycles", n, 32'd10);
    checkOutput("divz_done", {31'b0, done}, 32'h1);
    checkOutput("divz_lo", lo, 32'hFFFF_FFFD);
    checkOutput("divz_hi", hi, 32'hFFFF_FFFF);
    step();

    // DIV most-negative / -1
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    runToDone(n);
    checkOutput("ovf_lo", lo, 32'h8000_0000);
    checkOutput("ovf_hi", hi, 32'h0);
    step();

    // DIVU 100 / 7
    issue(4'd3, 32'd100, 32'd7);
    runToDone(n);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);
    step();

    // MTLO / MTHI take effect immediately without busy or done
    issue(4'd5, 32'h1234_5678, 32'h0);
    checkOutput("mtlo_lo", lo, 32'h1234_5678);
    checkOutput("mtlo_busy", {31'b0, busy}, 32'h0);
    checkOutput("mtlo_done", {31'b0, done}, 32'h0);
    issue(4'd4, 32'hAAAA_5555, 32'h0);
    checkOutput("mthi_hi", hi, 32'hAAAA_5555);
    checkOutput("mthi_lo", lo, 32'h1234_5678);

    // MULT 3*4 with a second MULT and an MTLO attempted while busy
    issue(4'd0, 32'd3, 32'd4);
    issue(4'd0, 32'd5, 32'd5);
    issue(4'd5, 32'hDEAD_BEEF, 32'h0);
    checkOutput("busy_mtlo_ignored", lo, 32'h1234_5678);
    runToDone(n);
    checkOutput("second_cycles", n, 32'd3);
    checkOutput("second_lo", lo, 32'd12);
    checkOutput("second_hi", hi, 32'd0);
    step();
    checkOutput("second_not_started", {31'b0, busy}, 32'h0);

    // start together with flush is suppressed
    flush = 1'b1;
    issue(4'd0, 32'd9, 32'd9);
    flush = 1'b0;
    checkOutput("flush_start_busy", {31'b0, busy}, 32'h0);
    checkOutput("flush_start_lo", lo, 32'd12);

    // MULTU with flush raised in busy cycle 3 still completes on schedule
    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    runToDone(n);
    checkOutput("flush_run_rest", n, 32'd2);
    checkOutput("flush_run_done", {31'b0, done}, 32'h1);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);

    // Back-to-back: start in the done cycle, signed MULT 0x80000000 * 2
    issue(4'd0, 32'h8000_0000, 32'd2);
    checkOutput("b2b_busy", {31'b0, busy}, 32'h1);
    runToDone(n);
    checkOutput("b2b_cycles", n, 32'd5);
    checkOutput("b2b_hi", hi, 32'hFFFF_FFFF);
    checkOutput("b2b_lo", lo, 32'h0);
    step();

    // Reset during busy cycle 4 of a DIV discards it with no done
    issue(4'd2, 32'd50, 32'd5);
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst_mid_hi", hi, 32'h0);
    checkOutput("rst_mid_lo", lo, 32'h0);
    checkOutput("rst_mid_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_mid_done", {31'b0, done}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("rst_mid_no_done", {31'b0, done}, 32'h0);
    end

    // Reset overrides a same-cycle MTLO
    reset = 1'b1;
    issue(4'd5, 32'h5555_AAAA, 32'h0);
    reset = 1'b0;
    checkOutput("rst_over_start", lo, 32'h0);

    // MADDU 1*1 onto {0, 0xFFFFFFFF}
    issue(4'd5, 32'hFFFF_FFFF, 32'h0);
    issue(4'd7, 32'd1, 32'd1);
`ifdef MULDIV_MADD_EN
    checkOutput("maddu_busy", {31'b0, busy}, 32'h1);
    runToDone(n);
    checkOutput("maddu_cycles", n, 32'd5);
    checkOutput("maddu_hi", hi, 32'h1);
    checkOutput("maddu_lo", lo, 32'h0);
`else
    checkOutput("maddu_busy", {31'b0, busy}, 32'h0);
    step(); step();
    checkOutput("maddu_done", {31'b0, done}, 32'h0);
    checkOutput("maddu_hi", hi, 32'h0);
    checkOutput("maddu_lo", lo, 32'hFFFF_FFFF);
`endif
    step();

    // Reserved op 12 is ignored
    issue(4'd12, 32'd3, 32'd3);
    checkOutput("reserved_busy", {31'b0, busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and width of each of HI and LO.
REQ-002 Parameter MULT_CYCLES, default 5: busy cycles for multiply-class ops; legal values are 1 or more.
REQ-003 Parameter DIV_CYCLES, default 10: busy cycles for divide ops; legal values are 1 or more.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  launch the op on md_op when high for one cycle.
REQ-007 flush  in  1  pipeline flush on interrupt or exception; suppresses a same-cycle start.
REQ-008 md_op  in  4  op code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 reserved.
REQ-009 src_a  in  WIDTH  rs operand (dividend or multiplicand).
REQ-010 src_b  in  WIDTH  rt operand (divisor or multiplier).
REQ-011 busy  out  1  an operation is in flight.
REQ-012 done  out  1  one-cycle pulse in the cycle after HI/LO commit.
REQ-013 hi  out  WIDTH  architectural HI register.
REQ-014 lo  out  WIDTH  architectural LO register.

Function
REQ-015 States: IDLE and RUN; a down-counter sized for max(MULT_CYCLES, DIV_CYCLES) tracks remaining busy cycles.
REQ-016 Accepted start = start & ~flush & ~busy & legal md_op; any other start is ignored with no state change.
REQ-017 Operands and md_op are captured at the accepting edge; later changes on src_a/src_b have no effect on the result.
REQ-018 MULT/MULTU/DIV/DIVU (and MADD-class when enabled): busy is high from the cycle after acceptance for exactly N cycles, where N = MULT_CYCLES or DIV_CYCLES.
REQ-019 HI/LO commit at the edge that ends the last busy cycle; busy=0 and done=1 in the following cycle.
REQ-020 hi/lo hold their old values throughout RUN; there is no partial-result visibility.
REQ-021 MULT/MULTU: {hi,lo} = the 2*WIDTH-bit signed or unsigned product.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, carrying the dividend's sign for signed ops.
REQ-023 Divide by zero: full DIV_CYCLES busy, done pulses, hi and lo are unchanged.
REQ-024 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
REQ-025 MTHI/MTLO: write src_a into hi or lo at the accepting edge; busy stays 0; done does not pulse.
REQ-026 MTHI/MTLO issued while busy is ignored (covered by REQ-016).
REQ-027 flush while busy does not abort the in-flight op; the op completes and commits normally.
REQ-028 A start accepted in the same cycle that done is high is legal and begins a new RUN.

Reset
REQ-029 When reset is high at an edge: hi=0, lo=0, busy=0, done=0, counter=0, state=IDLE.
REQ-030 Reset mid-operation discards the in-flight result; no done pulse follows.
REQ-031 Reset overrides a same-cycle start.

Configuration
REQ-032 Macro MULDIV_MADD_EN: when defined, ops 6-9 use MULT_CYCLES latency and commit {hi,lo} +/- product, signed for ops 6/8 and unsigned for 7/9, with 2*WIDTH wrap-around.
REQ-033 Without MULDIV_MADD_EN: ops 6-9 are reserved; start with them is ignored, busy stays 0, and hi/lo are unchanged.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-034 MULT with a=0xFFFFFFFE, b=3 at cycle T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1.
REQ-035 DIV with a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi/lo unchanged and done pulses.
REQ-036 MTLO a=0x12345678 -> lo=0x12345678 next cycle, busy=0; a second MULT issued while busy -> ignored, only the first result commits.
REQ-037 start and flush together -> busy stays 0; flush at busy cycle 3 of a MULT -> result still commits at cycle 5.
REQ-038 reset asserted at busy cycle 4 of a DIV -> next cycle hi=0, lo=0, busy=0, and no done pulse.
REQ-039 MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0; without the macro, the same op -> busy stays 0 and hi/lo are unchanged.
